// File: rtl/counter_sweep_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// counter_ctrl_pkg
// Shared definitions for the counter sweep controller: default widths and the
// controller state encoding.
// ---------------------------------------------------------------------------
package counter_ctrl_pkg;

  localparam int WIDTH_DEF = 8;  // counter value width
  localparam int REP_W_DEF = 4;  // width of the dwell and repeat fields

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOME,
    ST_UP,
    ST_HOLD_HI,
    ST_DOWN,
    ST_HOLD_LO,
    ST_DONE
  } state_e;

endpackage : counter_ctrl_pkg

// File: rtl/counter_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// counter_sweep_ctrl_if
// Bundles the sweep request, the external counter value and the controller
// outputs.
//   master : drives start/stop/lo/hi/dwell/reps/count, observes outputs
//   slave  : the controller side
// Signals:
//   start, stop            sweep request / abort
//   lo, hi                 sweep bounds
//   dwell, reps            hold length at each bound, number of sweeps
//   count                  current value of the external up/down counter
//   enable, direction      counter step enable, 1 = up
//   busy, done, err        status: active, completion pulse, rejected start
// ---------------------------------------------------------------------------
interface counter_sweep_ctrl_if
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int REP_W = REP_W_DEF
) ();

  logic             start;
  logic             stop;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [REP_W-1:0] dwell;
  logic [REP_W-1:0] reps;
  logic [WIDTH-1:0] count;
  logic             enable;
  logic             direction;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, stop, lo, hi, dwell, reps, count,
    input  enable, direction, busy, done, err
  );

  modport slave (
    input  start, stop, lo, hi, dwell, reps, count,
    output enable, direction, busy, done, err
  );

endinterface : counter_sweep_ctrl_if

// File: rtl/counter_sweep_ctrl_dwell_timer.sv
// ---------------------------------------------------------------------------
// dwell_timer
// Countdown used to time the hold at each sweep bound.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   load_i        load load_val_i (takes precedence over tick)
//   load_val_i    number of hold cycles, must be >= 1
//   tick_i        consume one hold cycle
//   expired_o     high during the last hold cycle
// ---------------------------------------------------------------------------
module dwell_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         tick_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  // The value loaded is the full hold length, so the hold ends in the cycle
  // where one remains.
  assign expired_o = (cnt_q <= W'(1));

endmodule : dwell_timer

// File: rtl/counter_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// counter_sweep_ctrl
// Drives an external up/down counter through repeated lo -> hi -> lo sweeps,
// holding at each bound. enable is combinational so the counter steps on the
// same edge the controller observes the bound, giving no overshoot.
// Ports:
//   clk   clock, all state changes on the rising edge
//   rst   asynchronous active-low reset
//   bus   counter_sweep_ctrl_if.slave (request, counter value, status)
// Configuration:
//   SWEEP_DWELL_EN  defined   : hold states last max(dwell,1) cycles
//                   undefined : dwell ignored, hold states last one cycle
// ---------------------------------------------------------------------------
module counter_sweep_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  counter_sweep_ctrl_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [REP_W-1:0] reps_q, reps_d;     // sweeps remaining, including current
  logic             err_q, err_d;

  logic             enable_c;
  logic             direction_c;
  logic             done_c;
  logic             tmr_load;
  logic             tmr_tick;
  logic             tmr_expired;

`ifdef SWEEP_DWELL_EN
  logic [REP_W-1:0] dwell_q, dwell_d;
  logic [REP_W-1:0] hold_len;

  assign hold_len = (dwell_q == '0) ? REP_W'(1) : dwell_q;

  dwell_timer #(.W(REP_W)) u_dwell_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (hold_len),
    .tick_i     (tmr_tick),
    .expired_o  (tmr_expired)
  );
`else
  // Without the timer every hold lasts exactly one cycle.
  assign tmr_expired = 1'b1;
  logic unused_dwell;
  assign unused_dwell = ^{bus.dwell, tmr_load, tmr_tick};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      reps_q  <= '0;
      err_q   <= 1'b0;
`ifdef SWEEP_DWELL_EN
      dwell_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      reps_q  <= reps_d;
      err_q   <= err_d;
`ifdef SWEEP_DWELL_EN
      dwell_q <= dwell_d;
`endif
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    reps_d      = reps_q;
    err_d       = 1'b0;
`ifdef SWEEP_DWELL_EN
    dwell_d     = dwell_q;
`endif
    enable_c    = 1'b0;
    direction_c = 1'b0;
    done_c      = 1'b0;
    tmr_load    = 1'b0;
    tmr_tick    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.lo >= bus.hi) begin
            err_d = 1'b1;
          end else begin
            lo_d    = bus.lo;
            hi_d    = bus.hi;
            reps_d  = (bus.reps == '0) ? REP_W'(1) : bus.reps;
`ifdef SWEEP_DWELL_EN
            dwell_d = bus.dwell;
`endif
            state_d = ST_HOME;
          end
        end
      end

      // Always count down to lo; below lo this wraps through zero.
      ST_HOME: begin
        enable_c = (bus.count != lo_q);
        if (bus.count == lo_q) state_d = ST_UP;
      end

      ST_UP: begin
        direction_c = 1'b1;
        enable_c    = (bus.count != hi_q);
        if (bus.count == hi_q) begin
          state_d  = ST_HOLD_HI;
          tmr_load = 1'b1;
        end
      end

      ST_HOLD_HI: begin
        direction_c = 1'b1;
        if (tmr_expired) state_d = ST_DOWN;
        else             tmr_tick = 1'b1;
      end

      ST_DOWN: begin
        enable_c = (bus.count != lo_q);
        if (bus.count == lo_q) begin
          state_d  = ST_HOLD_LO;
          tmr_load = 1'b1;
        end
      end

      ST_HOLD_LO: begin
        if (tmr_expired) begin
          reps_d  = (reps_q != '0) ? reps_q - REP_W'(1) : '0;
          state_d = (reps_q > REP_W'(1)) ? ST_UP : ST_DONE;
        end else begin
          tmr_tick = 1'b1;
        end
      end

      ST_DONE: begin
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Abort overrides every transition and silences the counter this cycle.
    if (bus.stop && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      reps_d   = reps_q;
      enable_c = 1'b0;
      done_c   = 1'b0;
      tmr_load = 1'b0;
      tmr_tick = 1'b0;
    end
  end

  assign bus.enable    = enable_c;
  assign bus.direction = direction_c;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = done_c;
  assign bus.err       = err_q;

endmodule : counter_sweep_ctrl

// File: tb/tb_counter_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_counter_sweep_ctrl
// Drives counter_sweep_ctrl with an 8-bit up/down counter model. Each started
// operation pushes its expected outcome (cycle of the done/err pulse, final
// count, enable steps, arrivals at hi) into a queue; a monitor pops it when
// the DUT pulses done or err.
// ---------------------------------------------------------------------------
module tb_counter_sweep_ctrl;

  localparam int W = 8;
  localparam int R = 4;

  typedef struct {
    bit is_err;
    int cyc;
    int fin;
    int ens;
    int arr;
    int hi;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_err;
  int   flush_req;
  logic         load_req;
  logic [W-1:0] load_val;
  exp_t sb[$];

  counter_sweep_ctrl_if #(.WIDTH(W), .REP_W(R)) bus ();

  counter_sweep_ctrl #(.WIDTH(W), .REP_W(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External up/down counter; load is a bench-only preset.
  always @(posedge clk) begin
    if (load_req)        bus.count <= load_val;
    else if (bus.enable) bus.count <= bus.direction ? bus.count + 8'd1 : bus.count - 8'd1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples just after the falling edge, once stimulus has settled.
  initial begin : monitor
    exp_t e;
    int   ens_acc;
    int   arr_acc;
    int   flush_seen;
    ens_acc = 0; arr_acc = 0; flush_seen = 0;
    forever begin
      @(negedge clk);
      #1;
      if (flush_req != flush_seen) begin
        flush_seen = flush_req;
        ens_acc = 0;
        arr_acc = 0;
      end
      if (rst) begin
        if (bus.enable) begin
          ens_acc++;
          if (bus.direction && sb.size() > 0 && !sb[0].is_err && int'(bus.count) == sb[0].hi - 1)
            arr_acc++;
        end
        if (bus.done || bus.err) begin
          if (sb.size() == 0) begin
            check("unexpected_event", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            check("event_is_err", int'(bus.err), int'(e.is_err));
            check("event_cycle", cyc, e.cyc);
            check("enable_steps", ens_acc, e.ens);
            if (!e.is_err) begin
              check("final_count", int'(bus.count), e.fin);
              check("hold_hi_visits", arr_acc, e.arr);
            end
          end
          ens_acc = 0;
          arr_acc = 0;
        end
      end
    end
  end

  // Reference: cycle-level cost of a sweep from the rules of operation.
  function automatic exp_t model(input int c, input int l, input int h,
                                 input int d, input int r, input int k);
    exp_t e;
    int   hsteps, rr, dd;
    e.hi = h;
    if (l >= h) begin
      e.is_err = 1'b1; e.cyc = k; e.fin = -1; e.ens = 0; e.arr = 0;
    end else begin
      rr     = (r == 0) ? 1 : r;
`ifdef SWEEP_DWELL_EN
      dd     = (d == 0) ? 1 : d;
`else
      dd     = (d >= 0) ? 1 : 1;
`endif
      hsteps = ((c - l) % 256 + 256) % 256;
      e.is_err = 1'b0;
      e.cyc    = k + (hsteps + 1) + rr * (2 * (h - l + 1) + 2 * dd) + 1 - 1;
      e.fin    = l;
      e.ens    = hsteps + rr * 2 * (h - l);
      e.arr    = rr;
    end
    return e;
  endfunction

  task automatic start_op(input int c, input int l, input int h, input int d,
                          input int r, input bit push);
    @(negedge clk);
    load_val = W'(c);
    load_req = 1'b1;
    @(negedge clk);
    load_req  = 1'b0;
    bus.lo    = W'(l);
    bus.hi    = W'(h);
    bus.dwell = R'(d);
    bus.reps  = R'(r);
    bus.start = 1'b1;
    if (push) sb.push_back(model(c, l, h, d, r, cyc + 1));
    @(negedge clk);
    bus.start = 1'b0;
    bus.lo    = W'($urandom);
    bus.hi    = W'($urandom);
    bus.dwell = R'($urandom);
    bus.reps  = R'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && sb.size() > 0; i++) @(negedge clk);
    check("drain_timeout", sb.size(), 0);
    sb.delete();
    flush_req++;
  endtask

  task automatic issue(input int c, input int l, input int h, input int d,
                       input int r, input bit poke);
    start_op(c, l, h, d, r, 1'b1);
    if (poke && l < h) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.lo    = 8'd0;
      bus.hi    = 8'd255;
      bus.reps  = 4'd7;
      bus.dwell = 4'd5;
      @(negedge clk);
      bus.start = 1'b0;
    end
    drain();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit hit;
    bit seen_hi;
    int l, h;
    n_checks = 0; n_err = 0; flush_req = 0;
    rst = 1'b0;
    load_req = 1'b0; load_val = '0;
    bus.start = 1'b0; bus.stop = 1'b0;
    bus.lo = '0; bus.hi = '0; bus.dwell = '0; bus.reps = '0;
    bus.count = '0;

    // Outputs held quiet in reset.
    repeat (3) @(negedge clk);
    check("rst_enable", int'(bus.enable), 0);
    check("rst_direction", int'(bus.direction), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err", int'(bus.err), 0);
    rst = 1'b1;

    // Basic sweep with dwell, single repetition.
    issue(5, 3, 6, 2, 1, 1'b0);
    check("idle_after_done", int'(bus.busy), 0);

    // Equal bounds rejected.
    issue(0, 6, 6, 1, 1, 1'b0);
    check("reject_busy", int'(bus.busy), 0);

    // Three sweeps.
    issue(3, 2, 4, 1, 3, 1'b0);

    // Homing through the wrap from below lo.
    issue(1, 250, 252, 0, 1, 1'b0);

    // Abort while counting up at count 4.
    start_op(2, 2, 7, 1, 1, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (bus.busy && bus.direction && bus.count == 8'd4) hit = 1'b1;
    end
    check("stop_reached_up4", int'(hit), 1);
    bus.stop = 1'b1;
    #1;
    check("stop_enable_same_cycle", int'(bus.enable), 0);
    @(negedge clk);
    bus.stop = 1'b0;
    check("stop_idle", int'(bus.busy), 0);
    check("stop_count_frozen", int'(bus.count), 4);
    repeat (3) @(negedge clk);
    check("stop_count_still", int'(bus.count), 4);
    flush_req++;

    // Reset while counting down.
    start_op(2, 2, 5, 1, 2, 1'b1);
    hit = 1'b0; seen_hi = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (bus.count == 8'd5) seen_hi = 1'b1;
      if (seen_hi && bus.busy && !bus.direction && bus.enable) hit = 1'b1;
    end
    check("rst_reached_down", int'(hit), 1);
    sb.delete();
    flush_req++;
    rst = 1'b0;
    #1;
    check("rst_mid_enable", int'(bus.enable), 0);
    check("rst_mid_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rel_enable", int'(bus.enable), 0);
    check("rel_busy", int'(bus.busy), 0);
    check("rel_done", int'(bus.done), 0);
    check("rel_err", int'(bus.err), 0);
    issue(7, 4, 9, 3, 2, 1'b0);

    // Randomised operations, some rejected, some poked with start while busy.
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        l = int'($urandom_range(0, 255));
        h = int'($urandom_range(0, l));
      end else begin
        l = int'($urandom_range(0, 249));
        h = l + int'($urandom_range(1, 6));
      end
      issue(int'($urandom_range(0, 255)), l, h, int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule : tb_counter_sweep_ctrl
